friscv_if_stage: RTL

- Instruction-fetch stage of the pipelined FRiscV core.
- Owns the program counter and drives the synchronous word-organised instruction memory with a byte address.
- Tracks the one-cycle in-flight read and loads the IF/ID pipeline register that feeds decode, where decode matches the opcode against the package OPCODES.
- Handles stall and branch/jump redirect from later stages.

---
 rtl/friscv_if_stage.sv | 88 ++++++++
 1 files changed

// File: rtl/friscv_if_stage.sv
// FRiscV instruction fetch: owns the PC, issues one imem read per advancing cycle and
// loads IF/ID one cycle later; redirect overrides stall and kills both wrong-path fetches.
module friscv_if_stage #(
  parameter int                ARCH            = 32,
  parameter int                IMEM_ADDR_WIDTH = 12,
  parameter logic [ARCH-1:0]   RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_i,
  input  logic                       redirect_i,
  input  logic [ARCH-1:0]            redirect_pc_i,
  output logic                       imem_en_o,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [ARCH-1:0]            imem_rdata_i,
  output logic [ARCH-1:0]            if_id_pc_o,
  output logic [ARCH-1:0]            if_id_instr_o,
  output logic                       if_id_valid_o,
  output logic                       misaligned_o
);

  localparam logic [ARCH-1:0] NOP = ARCH'(32'h0000_0013);

  logic [ARCH-1:0] pc_q, pc_d;
  logic [ARCH-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_valid_q, inflight_valid_d;
  logic [ARCH-1:0] if_id_pc_q, if_id_pc_d;
  logic [ARCH-1:0] if_id_instr_q, if_id_instr_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic            misaligned_q, misaligned_d;
  logic            advance;

  // A redirect always advances the stage, even if the hazard unit asks for a stall.
  assign advance     = !stall_i | redirect_i;
  assign imem_en_o   = advance;
  assign imem_addr_o = pc_q[IMEM_ADDR_WIDTH-1:0];

  always_comb begin
    pc_d             = pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_valid_d = inflight_valid_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_valid_d    = if_id_valid_q;
    misaligned_d     = redirect_i & |redirect_pc_i[1:0];

    if (redirect_i) begin
      pc_d = {redirect_pc_i[ARCH-1:2], 2'b00};
    end else if (!stall_i) begin
      pc_d = pc_q + ARCH'(4);
    end

    // imem holds rdata while disabled, so a held inflight entry still pairs with its data.
    if (advance) begin
      inflight_pc_d    = pc_q;
      inflight_valid_d = !redirect_i;
      if_id_pc_d       = inflight_pc_q;
      if_id_instr_d    = imem_rdata_i;
      if_id_valid_d    = inflight_valid_q & !redirect_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      inflight_pc_q    <= '0;
      inflight_valid_q <= 1'b0;
      if_id_pc_q       <= '0;
      if_id_instr_q    <= NOP;
      if_id_valid_q    <= 1'b0;
      misaligned_q     <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_valid_q <= inflight_valid_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_valid_q    <= if_id_valid_d;
      misaligned_q     <= misaligned_d;
    end
  end

  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_valid_o = if_id_valid_q;
  assign misaligned_o  = misaligned_q;

endmodule
